// File: rtl/wb_pkg.sv
// Shared definitions for the MEM/WB pipeline stage: write-back select codes,
// load funct3 codes, occupancy states and the default-width payload record.
package wb_pkg;

    localparam int WB_XLEN       = 32;
    localparam int WB_REG_ADDR_W = 5;
    localparam int WB_SEL_W      = 3;

    localparam logic [WB_SEL_W-1:0] WB_SEL_ALU   = 3'b000;
    localparam logic [WB_SEL_W-1:0] WB_SEL_MEM   = 3'b001;
    localparam logic [WB_SEL_W-1:0] WB_SEL_PC4   = 3'b010;
    localparam logic [WB_SEL_W-1:0] WB_SEL_IMMU  = 3'b011;
    localparam logic [WB_SEL_W-1:0] WB_SEL_PCIMM = 3'b100;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [WB_XLEN-1:0]       pc_plus_4;
        logic [WB_XLEN-1:0]       immu;
        logic [WB_XLEN-1:0]       pc_plus_immu;
        logic [WB_XLEN-1:0]       read_mem;
        logic [WB_XLEN-1:0]       alu_result;
        logic                     load;
        logic [2:0]               funct3;
        logic [WB_SEL_W-1:0]      wb_select;
        logic [WB_REG_ADDR_W-1:0] addr_wb;
        logic                     werf_enable;
    } wb_payload_t;

    localparam int WB_PAYLOAD_W = $bits(wb_payload_t);

endpackage

// File: rtl/wb_pipeline_stage_if.sv
// Handshake and payload bundle between MEM, the MEM/WB stage and write-back.
// The stage itself connects through the slave modport; the driver of the
// MEM side and consumer of the WB side use the master modport.
interface wb_pipeline_stage_if
    import wb_pkg::*;
#(
    parameter int XLEN       = WB_XLEN,
    parameter int REG_ADDR_W = WB_REG_ADDR_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       pc_plus_4_in;
    logic [XLEN-1:0]       immu_in;
    logic [XLEN-1:0]       pc_plus_immu_in;
    logic [XLEN-1:0]       read_mem_in;
    logic [XLEN-1:0]       alu_result_in;
    logic                  load_in;
    logic [2:0]            funct3_in;
    logic [WB_SEL_W-1:0]   wb_select_in;
    logic [REG_ADDR_W-1:0] addr_wb_in;
    logic                  werf_enable_in;

    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       pc_plus_4_out;
    logic [XLEN-1:0]       immu_out;
    logic [XLEN-1:0]       pc_plus_immu_out;
    logic [XLEN-1:0]       read_mem_out;
    logic [XLEN-1:0]       alu_result_out;
    logic                  load_out;
    logic [2:0]            funct3_out;
    logic [WB_SEL_W-1:0]   wb_select_out;
    logic [REG_ADDR_W-1:0] addr_wb_out;
    logic                  werf_enable_out;
    logic [XLEN-1:0]       wb_data;
    logic                  rf_we;

    modport slave (
        input  in_valid, pc_plus_4_in, immu_in, pc_plus_immu_in, read_mem_in,
               alu_result_in, load_in, funct3_in, wb_select_in, addr_wb_in,
               werf_enable_in, out_ready,
        output in_ready, out_valid, pc_plus_4_out, immu_out, pc_plus_immu_out,
               read_mem_out, alu_result_out, load_out, funct3_out, wb_select_out,
               addr_wb_out, werf_enable_out, wb_data, rf_we
    );

    modport master (
        output in_valid, pc_plus_4_in, immu_in, pc_plus_immu_in, read_mem_in,
               alu_result_in, load_in, funct3_in, wb_select_in, addr_wb_in,
               werf_enable_in, out_ready,
        input  in_ready, out_valid, pc_plus_4_out, immu_out, pc_plus_immu_out,
               read_mem_out, alu_result_out, load_out, funct3_out, wb_select_out,
               addr_wb_out, werf_enable_out, wb_data, rf_we
    );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load aligner: shifts the memory word by the byte offset and
// sign/zero-extends per funct3. Used only when WB_LOAD_ALIGN_EN is defined.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN
) (
    input  logic [XLEN-1:0] i_read_mem,
    input  logic [1:0]      i_offset,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_load_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(i_read_mem >> {i_offset, 3'b000});
    assign w_half = 16'(i_read_mem >> {i_offset, 3'b000});

    // Select and extend the addressed byte/halfword; a halfword at offset 3 straddles the word and reads as 0
    always_comb begin
        o_load_data = i_read_mem;
        case (i_funct3)
            F3_LB:   o_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_load_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH:   o_load_data = (i_offset == 2'd3) ? '0 : {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  o_load_data = (i_offset == 2'd3) ? '0 : {{(XLEN-16){1'b0}}, w_half};
            default: o_load_data = i_read_mem;
        endcase
    end

endmodule

// File: rtl/wb_pipeline_stage.sv
// MEM/WB pipeline stage: valid/ready handshake with a main + skid register so
// a write-back stall does not throttle MEM, plus write-back data selection.
// Optional feature: define WB_LOAD_ALIGN_EN to align/extend load data.
module wb_pipeline_stage
    import wb_pkg::*;
#(
    parameter int XLEN       = WB_XLEN,
    parameter int REG_ADDR_W = WB_REG_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    wb_pipeline_stage_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0]       pc_plus_4;
        logic [XLEN-1:0]       immu;
        logic [XLEN-1:0]       pc_plus_immu;
        logic [XLEN-1:0]       read_mem;
        logic [XLEN-1:0]       alu_result;
        logic                  load;
        logic [2:0]            funct3;
        logic [WB_SEL_W-1:0]   wb_select;
        logic [REG_ADDR_W-1:0] addr_wb;
        logic                  werf_enable;
    } payload_t;

    wb_state_e       r_state;
    wb_state_e       w_state_nxt;
    payload_t        r_main;
    payload_t        r_skid;
    payload_t        w_main_nxt;
    payload_t        w_skid_nxt;
    payload_t        w_in;
    logic            r_in_ready;
    logic            w_out_valid;
    logic            w_accept;
    logic            w_pop;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_wb_sel;

    assign w_in = '{
        pc_plus_4:    bus.pc_plus_4_in,
        immu:         bus.immu_in,
        pc_plus_immu: bus.pc_plus_immu_in,
        read_mem:     bus.read_mem_in,
        alu_result:   bus.alu_result_in,
        load:         bus.load_in,
        funct3:       bus.funct3_in,
        wb_select:    bus.wb_select_in,
        addr_wb:      bus.addr_wb_in,
        werf_enable:  bus.werf_enable_in
    };

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    // Occupancy transitions; the head always lives in main, the second entry in skid
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = w_in;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_pop) begin
                        w_state_nxt = ST_FULL;
                        w_skid_nxt  = w_in;
                    end else if (w_pop && !w_accept) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_accept && w_pop) begin
                        w_main_nxt  = w_in;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State and storage registers; in_ready is registered from the next occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
        end
    end

`ifdef WB_LOAD_ALIGN_EN
    wb_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_read_mem  (r_main.read_mem),
        .i_offset    (r_main.alu_result[1:0]),
        .i_funct3    (r_main.funct3),
        .o_load_data (w_load_data)
    );
`else
    assign w_load_data = r_main.read_mem;
`endif

    // Write-back source select for the head entry; unused codes fall back to the ALU result
    always_comb begin
        w_wb_sel = r_main.alu_result;
        case (r_main.wb_select)
            WB_SEL_ALU:   w_wb_sel = r_main.alu_result;
            WB_SEL_MEM:   w_wb_sel = w_load_data;
            WB_SEL_PC4:   w_wb_sel = r_main.pc_plus_4;
            WB_SEL_IMMU:  w_wb_sel = r_main.immu;
            WB_SEL_PCIMM: w_wb_sel = r_main.pc_plus_immu;
            default:      w_wb_sel = r_main.alu_result;
        endcase
    end

    assign bus.in_ready         = r_in_ready;
    assign bus.out_valid        = w_out_valid;
    assign bus.pc_plus_4_out    = r_main.pc_plus_4;
    assign bus.immu_out         = r_main.immu;
    assign bus.pc_plus_immu_out = r_main.pc_plus_immu;
    assign bus.read_mem_out     = r_main.read_mem;
    assign bus.alu_result_out   = r_main.alu_result;
    assign bus.load_out         = r_main.load;
    assign bus.funct3_out       = r_main.funct3;
    assign bus.wb_select_out    = r_main.wb_select;
    assign bus.addr_wb_out      = r_main.addr_wb;
    assign bus.werf_enable_out  = r_main.werf_enable;
    assign bus.wb_data          = w_out_valid ? w_wb_sel : '0;
    assign bus.rf_we            = w_out_valid & r_main.werf_enable & (r_main.addr_wb != '0);

endmodule

// File: tb/tb_wb_pipeline_stage.sv
// Self-checking bench for wb_pipeline_stage: directed scenarios followed by
// randomized traffic, all compared against a 2-deep FIFO reference model.
module tb_wb_pipeline_stage;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    wb_pipeline_stage_if #(.XLEN(WB_XLEN), .REG_ADDR_W(WB_REG_ADDR_W)) bus();

    wb_pipeline_stage #(
        .XLEN       (WB_XLEN),
        .REG_ADDR_W (WB_REG_ADDR_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    wb_payload_t model_q[$];

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Load data from the architectural rules, using plain arithmetic
    function automatic logic [31:0] exp_load(input wb_payload_t p);
`ifdef WB_LOAD_ALIGN_EN
        logic [31:0] off;
        logic [31:0] sh;
        logic [31:0] b;
        logic [31:0] h;
        off = p.alu_result % 4;
        sh  = p.read_mem / (32'd1 << (8 * off));
        b   = sh % 256;
        h   = sh % 65536;
        case (p.funct3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (off == 3) ? 32'd0 : ((h >= 32768) ? h + 32'hFFFF_0000 : h);
            3'b101:  return (off == 3) ? 32'd0 : h;
            default: return p.read_mem;
        endcase
`else
        return p.read_mem;
`endif
    endfunction

    function automatic logic [31:0] exp_wb(input wb_payload_t p);
        case (p.wb_select)
            3'd0:    return p.alu_result;
            3'd1:    return exp_load(p);
            3'd2:    return p.pc_plus_4;
            3'd3:    return p.immu;
            3'd4:    return p.pc_plus_immu;
            default: return p.alu_result;
        endcase
    endfunction

    function automatic wb_payload_t dut_payload();
        wb_payload_t d;
        d.pc_plus_4    = bus.pc_plus_4_out;
        d.immu         = bus.immu_out;
        d.pc_plus_immu = bus.pc_plus_immu_out;
        d.read_mem     = bus.read_mem_out;
        d.alu_result   = bus.alu_result_out;
        d.load         = bus.load_out;
        d.funct3       = bus.funct3_out;
        d.wb_select    = bus.wb_select_out;
        d.addr_wb      = bus.addr_wb_out;
        d.werf_enable  = bus.werf_enable_out;
        return d;
    endfunction

    function automatic wb_payload_t rand_payload();
        wb_payload_t p;
        p.pc_plus_4    = $urandom;
        p.immu         = $urandom;
        p.pc_plus_immu = $urandom;
        p.read_mem     = $urandom;
        p.alu_result   = $urandom;
        p.load         = 1'($urandom_range(0, 1));
        p.funct3       = 3'($urandom_range(0, 7));
        p.wb_select    = 3'($urandom_range(0, 7));
        p.addr_wb      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        p.werf_enable  = 1'($urandom_range(0, 3) != 0);
        return p;
    endfunction

    task automatic compare_model();
        chk("out_valid", bus.out_valid, model_q.size() > 0);
        chk("in_ready", bus.in_ready, model_q.size() < 2);
        if (model_q.size() > 0) begin
            chk("payload", dut_payload(), model_q[0]);
            chk("wb_data", bus.wb_data, exp_wb(model_q[0]));
            chk("rf_we", bus.rf_we, model_q[0].werf_enable && (model_q[0].addr_wb != 0));
        end else begin
            chk("wb_data_idle", bus.wb_data, 0);
            chk("rf_we_idle", bus.rf_we, 0);
        end
    endtask

    // One clock: drive inputs, update the FIFO model at the edge, check at the falling edge
    task automatic tick(input logic iv, input logic ordy, input logic fl, input logic rn,
                        input wb_payload_t p);
        bit pop;
        bit acc;
        rst_n               = rn;
        flush               = fl;
        bus.in_valid        = iv;
        bus.out_ready       = ordy;
        bus.pc_plus_4_in    = p.pc_plus_4;
        bus.immu_in         = p.immu;
        bus.pc_plus_immu_in = p.pc_plus_immu;
        bus.read_mem_in     = p.read_mem;
        bus.alu_result_in   = p.alu_result;
        bus.load_in         = p.load;
        bus.funct3_in       = p.funct3;
        bus.wb_select_in    = p.wb_select;
        bus.addr_wb_in      = p.addr_wb;
        bus.werf_enable_in  = p.werf_enable;
        @(posedge clk);
        if (!rn || fl) begin
            model_q.delete();
        end else begin
            pop = (model_q.size() > 0) && ordy;
            acc = iv && (model_q.size() < 2);
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back(p);
        end
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        wb_payload_t p0;
        wb_payload_t p;
        logic [31:0] exp_lb;
        logic [31:0] exp_lbu;
        logic [31:0] exp_lh;
        p0 = '0;

        tick(1'b0, 1'b0, 1'b0, 1'b0, p0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, rand_payload());
        chk("rst_outputs", dut_payload(), '0);
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // Single entry
        p = '0; p.alu_result = 32'h1234; p.wb_select = 3'b000; p.addr_wb = 5'd5; p.werf_enable = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b1, p);
        chk("t1_valid", bus.out_valid, 1'b1);
        chk("t1_wb_data", bus.wb_data, 32'h1234);
        chk("t1_rf_we", bus.rf_we, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1, p0);
        chk("t1_drained", bus.out_valid, 1'b0);

        // Backpressure
        p = '0; p.alu_result = 32'hA; tick(1'b1, 1'b0, 1'b0, 1'b1, p);
        p.alu_result = 32'hB;         tick(1'b1, 1'b0, 1'b0, 1'b1, p);
        chk("t2_full_ready", bus.in_ready, 1'b0);
        chk("t2_head_a", bus.wb_data, 32'hA);
        tick(1'b0, 1'b1, 1'b0, 1'b1, p0);
        chk("t2_head_b", bus.wb_data, 32'hB);
        chk("t2_ready_back", bus.in_ready, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1, p0);
        chk("t2_empty", bus.out_valid, 1'b0);

        // Streaming
        for (int i = 0; i < 8; i++) begin
            p = '0; p.alu_result = 32'(100 + i);
            tick(1'b1, 1'b1, 1'b0, 1'b1, p);
            chk("t3_ready", bus.in_ready, 1'b1);
            chk("t3_data", bus.wb_data, 32'(100 + i));
        end
        tick(1'b0, 1'b1, 1'b0, 1'b1, p0);

        // Flush while full with a same-cycle push
        p = '0; p.alu_result = 32'h11; tick(1'b1, 1'b0, 1'b0, 1'b1, p);
        p.alu_result = 32'h22;         tick(1'b1, 1'b0, 1'b0, 1'b1, p);
        p.alu_result = 32'hDEAD;       tick(1'b1, 1'b0, 1'b1, 1'b1, p);
        chk("t4_valid", bus.out_valid, 1'b0);
        chk("t4_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1, p0);
            chk("t4_no_ghost", bus.out_valid, 1'b0);
        end

        // Destination x0
        p = '0; p.alu_result = 32'h77; p.addr_wb = 5'd0; p.werf_enable = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b1, p);
        chk("t5_valid", bus.out_valid, 1'b1);
        chk("t5_rf_we", bus.rf_we, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, p0);

        // Load data
`ifdef WB_LOAD_ALIGN_EN
        exp_lb = 32'hFFFF_FFFF; exp_lbu = 32'h0000_00FF; exp_lh = 32'hFFFF_80FF;
`else
        exp_lb = 32'h80FF_7F01; exp_lbu = 32'h80FF_7F01; exp_lh = 32'h80FF_7F01;
`endif
        p = '0; p.read_mem = 32'h80FF_7F01; p.alu_result = 32'h2; p.wb_select = 3'b001; p.load = 1'b1;
        p.funct3 = 3'b000; tick(1'b1, 1'b1, 1'b0, 1'b1, p);
        chk("t6_lb", bus.wb_data, exp_lb);
        p.funct3 = 3'b100; tick(1'b1, 1'b1, 1'b0, 1'b1, p);
        chk("t6_lbu", bus.wb_data, exp_lbu);
        p.funct3 = 3'b001; tick(1'b1, 1'b1, 1'b0, 1'b1, p);
        chk("t6_lh", bus.wb_data, exp_lh);
        chk("t6_funct3_out", bus.funct3_out, 3'b001);
        tick(1'b0, 1'b1, 1'b0, 1'b1, p0);

        // Randomized traffic with varying backpressure, flushes and resets
        for (int i = 0; i < 800; i++) begin
            int unsigned phase;
            logic iv;
            logic ordy;
            phase = 32'(i / 200);
            iv    = ($urandom_range(0, 3) != 0);
            ordy  = (phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick(iv, ordy, ($urandom_range(0, 40) == 0), ($urandom_range(0, 100) != 0), rand_payload());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
